// File: rtl/alu_pkg.sv
// Shared ALU definitions: condition codes, flag bit positions, ALU opcodes
// and the branch-condition evaluator used by the execute-stage output register.
package alu_pkg;

    typedef enum logic [2:0] {
        AL = 3'b000,
        EQ = 3'b001,
        NE = 3'b010,
        CS = 3'b011,
        CC = 3'b100,
        MI = 3'b101,
        LT = 3'b110,
        GE = 3'b111
    } cond_e;

    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_S = 1;
    localparam int FLAG_V = 0;

    // ALU_Control encodings of the upstream ALU
    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_OR  = 4'h3;
    localparam logic [3:0] ALU_XOR = 4'h4;
    localparam logic [3:0] ALU_SLL = 4'h5;
    localparam logic [3:0] ALU_SRL = 4'h6;
    localparam logic [3:0] ALU_SRA = 4'h7;
    localparam logic [3:0] ALU_SLT = 4'h8;
    localparam logic [3:0] ALU_MUL = 4'h9;

    function automatic logic cond_eval(cond_e c, logic [3:0] flags);
        logic r;
        case (c)
            AL:      r = 1'b1;
            EQ:      r = flags[FLAG_Z];
            NE:      r = !flags[FLAG_Z];
            CS:      r = flags[FLAG_C];
            CC:      r = !flags[FLAG_C];
            MI:      r = flags[FLAG_S];
            LT:      r = flags[FLAG_S] ^ flags[FLAG_V];
            GE:      r = !(flags[FLAG_S] ^ flags[FLAG_V]);
            default: r = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_result_stage_fifo.sv
// Generic 2-entry valid/ready buffer with a registered in_ready, so the
// downstream ready never reaches the upstream ready combinationally.
module pipe_fifo2 #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [1:0]       count;
    logic [1:0]       count_next;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;
    logic             push;
    logic             pop;

    assign out_valid = (count != 2'd0);
    assign out_data  = head;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        count_next = count;
        if (flush)
            count_next = 2'd0;
        else if (push && !pop)
            count_next = count + 2'd1;
        else if (pop && !push)
            count_next = count - 2'd1;
    end

    // head is always the oldest entry; it keeps its value once drained
    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= 2'd0;
            in_ready <= 1'b1;
            head     <= '0;
            tail     <= '0;
        end else begin
            count    <= count_next;
            in_ready <= (count_next < 2'(DEPTH));
            if (!flush) begin
                if (pop) begin
                    if (count == 2'd2)
                        head <= tail;
                    else if (push)
                        head <= in_data;
                end else if (push) begin
                    if (count == 2'd0)
                        head <= in_data;
                    else
                        tail <= in_data;
                end
            end
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// Execute-stage output register: buffers ALU results with their branch outcome
// and maintains the architectural {Z,C,S,V} flag register.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             zero_flag,
    input  logic             carry_flag,
    input  logic             sign_flag,
    input  logic             overflow_flag,
    input  logic             set_flags,
    input  logic [2:0]       cond,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_taken,
    output logic [3:0]       flags_q
);

    logic [3:0] alu_flags;
    logic [3:0] eval_flags;
    logic       taken;
    logic       accept;

    assign alu_flags  = {zero_flag, carry_flag, sign_flag, overflow_flag};
    // flag-setting ops branch on their own flags, others on the committed ones
    assign eval_flags = set_flags ? alu_flags : flags_q;
    assign taken      = cond_eval(cond_e'(cond), eval_flags);
    assign accept     = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset)
            flags_q <= 4'b0000;
        else if (accept && set_flags && !flush)
            flags_q <= alu_flags;
    end

    pipe_fifo2 #(
        .WIDTH(WIDTH + 1),
        .DEPTH(DEPTH)
    ) u_buf (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  ({taken, alu_result}),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data ({out_taken, out_result})
    );

endmodule
